// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg
//   Shared definitions for the bit-serial arithmetic blocks of the benchmark
//   suite: the control state encoding, the default operand width and the
//   helper that sizes the per-bit counter.
package serial_arith_pkg;

  // Control states shared by the serial arithmetic blocks.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 5;

  // Width of the bit counter for a given operand width (operand width >= 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// serial_sub_cell
//   Combinational 1-bit full subtractor: computes a - b - br.
// Ports:
//   a       in   minuend bit
//   b       in   subtrahend bit
//   br      in   incoming borrow
//   d       out  difference bit
//   br_next out  borrow propagated to the next more significant bit
module serial_sub_cell (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic br_next
);

  assign d = a ^ b ^ br;

  // A borrow leaves this bit when b exceeds a outright, or when a and b are
  // equal and an incoming borrow has to be passed further up.
  assign br_next = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle bit-serial subtractor: diff = minuend - subtrahend - borrow_in
//   (mod 2^WIDTH) with a final borrow_out. Operands are taken through a
//   valid/ready handshake, processed LSB first at one bit per clock, and the
//   result is offered through a second valid/ready handshake.
// Parameters:
//   WIDTH       operand and difference width in bits (>= 2)
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    operand word present
//   in_ready    block can accept operands (state IDLE)
//   minuend     operand A
//   subtrahend  operand B
//   borrow_in   initial borrow
//   out_valid   result present (state DONE)
//   out_ready   consumer takes result
//   diff        A - B - borrow_in, modulo 2^WIDTH
//   borrow_out  1 iff A < B + borrow_in (unsigned)
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_reg;
  logic             br_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_br_next;
  logic             last_bit;
  logic             accept;

  serial_sub_cell u_cell (
    .a       (a_sr[0]),
    .b       (b_sr[0]),
    .br      (br_reg),
    .d       (cell_d),
    .br_next (cell_br_next)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake flags depend on the state alone, so no input reaches an output
  // combinationally. An out_ready/in_valid pair seen in DONE only completes
  // the output side; the new operand is picked up from IDLE afterwards.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath. Each RUN cycle consumes the LSBs of both shift registers and
  // shifts the difference bit in at the MSB, so after WIDTH shifts bit i of
  // the result sits at diff_reg[i]. Outside IDLE the operand inputs are not
  // looked at, and in DONE everything is frozen until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      diff_reg   <= '0;
      br_reg     <= 1'b0;
      borrow_reg <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr     <= minuend;
            b_sr     <= subtrahend;
            br_reg   <= borrow_in;
            cnt      <= '0;
            diff_reg <= '0;
          end
        end
        RUN: begin
          diff_reg <= {cell_d, diff_reg[WIDTH-1:1]};
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          br_reg   <= cell_br_next;
          cnt      <= cnt + CW'(1);
          if (last_bit) begin
            borrow_reg <= cell_br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff       = diff_reg;
  assign borrow_out = borrow_reg;

endmodule
